fft_result_buffer: RTL
======================

Name: fft_result_buffer

Overview:
Downstream capture stage for the FFT core. It collects one frame of complex results on the FFT's out_valid/dout_r/dout_i stream and stores each result as a packed 32-bit word. The RS5 reads the frame back over a memory-mapped word interface. A status register and a level interrupt report frame completion and overrun.

Parameters:
N_POINTS, 64, results per frame; power of two, 8..1024
DATA_W, 16, width of each FFT output component
ADDR_W, $clog2(N_POINTS)+1, word-address width; MSB selects the buffer region

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
out_valid_i  in  1  FFT result strobe, one result per cycle while high
dout_r_i  in  DATA_W  FFT real output
dout_i_i  in  DATA_W  FFT imaginary output
bus_en_i  in  1  CPU access strobe, one cycle per access
bus_we_i  in  4  byte write enables; any bit set means a write
bus_addr_i  in  ADDR_W  word address
bus_data_i  in  32  write data
bus_data_o  out  32  read data
done_irq_o  out  1  frame-complete interrupt, level

Behaviour:
- Reset: all outputs 0, state IDLE, count 0, done 0, overflow 0; buffer contents undefined.
- Address map (bus_addr_i):
  - MSB=1: buffer word index = low log2(N_POINTS) bits; read-only, writes ignored.
  - MSB=0, index 0: CTRL. bit0 ARM, bit1 CLEAR; write-1-pulse, reads 0.
  - MSB=0, index 1: STATUS, read-only. bit0 busy, bit1 done, bit2 overflow, [31:16] count.
  - MSB=0, other indices: read 0.
- Reads: 1-cycle latency. bus_data_o is registered on bus_en_i with bus_we_i==0 and holds its value until the next read.
- Packed word format: {dout_i_i, dout_r_i}, with real in [15:0] for DATA_W=16. For DATA_W<16, each half is sign-extended to 16 bits.
- State machine:
  - IDLE: out_valid_i ignored. ARM -> CAPTURE with count=0, done=0, overflow=0.
  - CAPTURE: each cycle with out_valid_i writes buf[count] and increments count. The write that makes count==N_POINTS moves to DONE and sets done=1 on the next edge.
  - DONE: done_irq_o=1. out_valid_i sets overflow=1; buffer and count are unchanged. ARM re-enters CAPTURE and clears done/overflow/count.
- busy = (state==CAPTURE).
- Boundaries:
  - ARM while in CAPTURE: restart, count=0; the sample on that cycle is discarded.
  - ARM and out_valid_i in the same cycle from IDLE: that sample is discarded; capture starts the next cycle.
  - CLEAR (any state): IDLE, count=0, done=0, overflow=0. CLEAR has priority over a simultaneous ARM.
  - count saturates at N_POINTS and never wraps.
  - Reading the buffer during CAPTURE returns whatever the location holds (no stall or hazard interlock). A same-cycle write and read of the same index returns the old data.
  - rst mid-frame: immediate return to IDLE; partial data is not flagged.
- done_irq_o = done; it falls only on CLEAR, ARM, or rst.

Decomposition:
- Shared package fft_pkg:
  - FFT_OUT_W=16, FFT_IN_W=12
  - capture state enum cap_state_e {CAP_IDLE, CAP_CAPTURE, CAP_DONE}
  - register indices REG_CTRL=0, REG_STATUS=1
  - CTRL/STATUS bit positions
- One sub-module, fft_buf_ram: simple dual-port RAM, N_POINTS x 32, one synchronous write port and one registered read port. Behavioural so ASIC/FPGA flows can infer or replace it.

Test Plan:
- Reset release, read STATUS -> 0x00000000; done_irq_o=0; CTRL reads 0.
- Arm, then stream 64 results with dout_r=k, dout_i=-k (k=0..63) -> STATUS=0x00400002, done_irq_o=1 on the cycle after the 64th result; buf[5]=0xFFFB0005.
- After DONE, apply 3 extra out_valid cycles -> STATUS=0x00400006 and buf[0] unchanged (0x00000000). Then CLEAR -> STATUS=0, done_irq_o=0.
- ARM written in the same cycle as a result with value 0x1111 -> that sample is dropped; buf[0] holds the next result.
- Re-ARM after 10 captured results -> count restarts; the next result lands in buf[0] and STATUS[31:16]=1.
- Assert rst after 20 results -> STATUS=0 and IRQ low immediately (asynchronously). Out_valid afterwards is ignored until ARM.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and types for the FFT result capture path
package fft_pkg;

    localparam int FFT_OUT_W = 16;
    localparam int FFT_IN_W  = 12;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_CAPTURE = 2'd1,
        CAP_DONE    = 2'd2
    } cap_state_e;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;

    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 16;

endpackage

// File: rtl/fft_result_buffer_if.sv
// rtl/fft_result_buffer_if.sv - FFT result stream plus CPU word bus for the result buffer
interface fft_result_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
);
    logic              out_valid_i;
    logic [DATA_W-1:0] dout_r_i;
    logic [DATA_W-1:0] dout_i_i;
    logic              bus_en_i;
    logic [3:0]        bus_we_i;
    logic [ADDR_W-1:0] bus_addr_i;
    logic [31:0]       bus_data_i;
    logic [31:0]       bus_data_o;
    logic              done_irq_o;

    modport slave (
        input  out_valid_i, dout_r_i, dout_i_i,
        input  bus_en_i, bus_we_i, bus_addr_i, bus_data_i,
        output bus_data_o, done_irq_o
    );

    modport master (
        output out_valid_i, dout_r_i, dout_i_i,
        output bus_en_i, bus_we_i, bus_addr_i, bus_data_i,
        input  bus_data_o, done_irq_o
    );
endinterface

// File: rtl/fft_buf_ram.sv
// rtl/fft_buf_ram.sv - behavioural simple dual-port RAM with registered read
module fft_buf_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Read-before-write: a same-cycle write to the read index returns the old word
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_result_buffer.sv
// rtl/fft_result_buffer.sv - captures one FFT frame and serves it to the CPU
module fft_result_buffer
    import fft_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = $clog2(N_POINTS) + 1
) (
    input  logic               clk,
    input  logic               rst,
    fft_result_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(N_POINTS);
    localparam int CNT_W = IDX_W + 1;

    cap_state_e       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_overflow;
    logic             r_rd_buf;
    logic [31:0]      r_reg_rdata;

    logic                 w_reg_sel;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_bus_wr;
    logic                 w_bus_rd;
    logic                 w_ctrl_wr;
    logic                 w_arm;
    logic                 w_clear;
    logic                 w_cap_we;
    logic [FFT_OUT_W-1:0] w_re_ext;
    logic [FFT_OUT_W-1:0] w_im_ext;
    logic [31:0]          w_status;
    logic [31:0]          w_reg_rdata;
    logic [31:0]          w_ram_rdata;
    logic                 w_unused;

    assign w_reg_sel = ~bus.bus_addr_i[ADDR_W-1];
    assign w_idx     = bus.bus_addr_i[IDX_W-1:0];
    assign w_bus_wr  = bus.bus_en_i & (|bus.bus_we_i);
    assign w_bus_rd  = bus.bus_en_i & ~(|bus.bus_we_i);
    assign w_ctrl_wr = w_bus_wr & w_reg_sel & (w_idx == IDX_W'(REG_CTRL));
    assign w_arm     = w_ctrl_wr & bus.bus_data_i[CTRL_ARM_BIT];
    assign w_clear   = w_ctrl_wr & bus.bus_data_i[CTRL_CLEAR_BIT];

    // A sample coinciding with ARM or CLEAR is dropped, so the write port is gated by both
    assign w_cap_we  = (r_state == CAP_CAPTURE) & bus.out_valid_i & ~w_arm & ~w_clear;

    assign w_re_ext  = FFT_OUT_W'($signed(bus.dout_r_i));
    assign w_im_ext  = FFT_OUT_W'($signed(bus.dout_i_i));

    assign w_unused  = &{1'b0, bus.bus_data_i[31:2]};

    // Capture state machine; CLEAR outranks ARM, ARM outranks incoming samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CAP_IDLE;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_state    <= CAP_IDLE;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_arm) begin
            r_state    <= CAP_CAPTURE;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                CAP_CAPTURE: begin
                    if (bus.out_valid_i && (r_count != CNT_W'(N_POINTS))) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == CNT_W'(N_POINTS - 1)) begin
                            r_state <= CAP_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                CAP_DONE: begin
                    if (bus.out_valid_i) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status word assembled from live state
    always_comb begin
        w_status                              = '0;
        w_status[STAT_BUSY_BIT]               = (r_state == CAP_CAPTURE);
        w_status[STAT_DONE_BIT]               = r_done;
        w_status[STAT_OVF_BIT]                = r_overflow;
        w_status[STAT_COUNT_LSB +: 16]        = 16'(r_count);
    end

    // Register-space read decode; CTRL and unmapped indices read as zero
    always_comb begin
        w_reg_rdata = '0;
        if (w_idx == IDX_W'(REG_STATUS)) begin
            w_reg_rdata = w_status;
        end
    end

    // Latch which region the last read hit, plus register data, so the output holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_buf    <= 1'b0;
            r_reg_rdata <= '0;
        end else if (w_bus_rd) begin
            r_rd_buf    <= ~w_reg_sel;
            r_reg_rdata <= w_reg_rdata;
        end
    end

    fft_buf_ram #(
        .DEPTH (N_POINTS),
        .AW    (IDX_W),
        .DW    (32)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_cap_we),
        .i_waddr (r_count[IDX_W-1:0]),
        .i_wdata ({w_im_ext, w_re_ext}),
        .i_re    (w_bus_rd & ~w_reg_sel),
        .i_raddr (w_idx),
        .o_rdata (w_ram_rdata)
    );

    assign bus.bus_data_o = r_rd_buf ? w_ram_rdata : r_reg_rdata;
    assign bus.done_irq_o = r_done;
endmodule
